// File: rtl/hovalaag_in_queue.sv
// Dual-channel show-ahead input queue feeding the Hovalaag core IN1/IN2; zero-latency head, sticky underflow.
// Optional HOVALAAG_INQ_HOLD_EN: an empty channel presents its last popped word instead of 0.
module hovalaag_in_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              wr_sel,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WIDTH-1:0]  IN1,
  input  logic              IN1_adv,
  output logic [WIDTH-1:0]  IN2,
  input  logic              IN2_adv,
  output logic [ADDR_W:0]   count1,
  output logic [ADDR_W:0]   count2,
  output logic              underflow1,
  output logic              underflow2,
  input  logic              clr_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [2][DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q [2];
  logic [ADDR_W-1:0] wr_ptr_d [2];
  logic [ADDR_W-1:0] rd_ptr_q [2];
  logic [ADDR_W-1:0] rd_ptr_d [2];
  logic [ADDR_W:0]   count_q  [2];
  logic [ADDR_W:0]   count_d  [2];
  logic [1:0]        uflow_q, uflow_d;
  logic [1:0]        full, empty, push, pop, uflow_evt, adv;
  logic [WIDTH-1:0]  head   [2];
  logic [WIDTH-1:0]  in_val [2];
`ifdef HOVALAAG_INQ_HOLD_EN
  logic [WIDTH-1:0]  hold_q [2];
`endif

  assign adv = {IN2_adv, IN1_adv};

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]      = (count_q[c] == DEPTH_C);
      empty[c]     = (count_q[c] == '0);
      push[c]      = wr_valid && (int'(wr_sel) == c) && !full[c];
      // A pop against an empty channel is an underflow even if a push lands this cycle.
      pop[c]       = adv[c] && !empty[c];
      uflow_evt[c] = adv[c] && empty[c];
      wr_ptr_d[c]  = push[c] ? wr_ptr_q[c] + ADDR_W'(1) : wr_ptr_q[c];
      rd_ptr_d[c]  = pop[c]  ? rd_ptr_q[c] + ADDR_W'(1) : rd_ptr_q[c];
      count_d[c]   = count_q[c];
      if (push[c] && !pop[c]) begin
        count_d[c] = count_q[c] + (ADDR_W+1)'(1);
      end else if (pop[c] && !push[c]) begin
        count_d[c] = count_q[c] - (ADDR_W+1)'(1);
      end
      uflow_d[c]   = (uflow_q[c] && !clr_err) || uflow_evt[c];
      head[c]      = mem_q[c][rd_ptr_q[c]];
`ifdef HOVALAAG_INQ_HOLD_EN
      in_val[c]    = empty[c] ? hold_q[c] : head[c];
`else
      in_val[c]    = empty[c] ? '0 : head[c];
`endif
    end
  end

  assign wr_ready   = !full[wr_sel];
  assign IN1        = in_val[0];
  assign IN2        = in_val[1];
  assign count1     = count_q[0];
  assign count2     = count_q[1];
  assign underflow1 = uflow_q[0];
  assign underflow2 = uflow_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
`ifdef HOVALAAG_INQ_HOLD_EN
        hold_q[c]   <= '0;
`endif
      end
      uflow_q <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c]  <= count_d[c];
`ifdef HOVALAAG_INQ_HOLD_EN
        if (pop[c]) hold_q[c] <= head[c];
`endif
      end
      uflow_q <= uflow_d;
    end
  end

  // Storage needs no reset: occupancy gates everything read from it.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= wr_data;
    end
  end

endmodule

// File: tb/tb_hovalaag_in_queue.sv
// Bench for hovalaag_in_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_hovalaag_in_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] wr_data;
  logic        wr_sel, wr_valid, wr_ready;
  logic [11:0] IN1, IN2;
  logic        IN1_adv, IN2_adv, clr_err;
  logic [4:0]  count1, count2;
  logic        underflow1, underflow2;

  int total = 0;
  int bad   = 0;

  logic [11:0] q1[$];
  logic [11:0] q2[$];
  logic        uf1_m, uf2_m;
  logic [11:0] hold1_m, hold2_m;

  hovalaag_in_queue dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_sel(wr_sel), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .IN1(IN1), .IN1_adv(IN1_adv), .IN2(IN2), .IN2_adv(IN2_adv),
    .count1(count1), .count2(count2), .underflow1(underflow1), .underflow2(underflow2),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] exp_in(input int c);
    if (c == 1) begin
      if (q1.size() > 0) return q1[0];
`ifdef HOVALAAG_INQ_HOLD_EN
      return hold1_m;
`else
      return 12'h000;
`endif
    end
    if (q2.size() > 0) return q2[0];
`ifdef HOVALAAG_INQ_HOLD_EN
    return hold2_m;
`else
    return 12'h000;
`endif
  endfunction

  task automatic model_clear();
    q1.delete(); q2.delete();
    uf1_m = 1'b0; uf2_m = 1'b0;
    hold1_m = '0; hold2_m = '0;
  endtask

  task automatic idle();
    wr_valid = 0; wr_sel = 0; wr_data = '0; IN1_adv = 0; IN2_adv = 0; clr_err = 0;
  endtask

  // One clock with the given inputs; the model advances from its pre-edge state.
  task automatic tick(input logic wv, input logic sel, input logic [11:0] d,
                      input logic a1, input logic a2, input logic clr);
    bit p1, p2, o1, o2, u1, u2;
    wr_valid = wv; wr_sel = sel; wr_data = d; IN1_adv = a1; IN2_adv = a2; clr_err = clr;
    p1 = wv && !sel && (q1.size() < 16);
    p2 = wv &&  sel && (q2.size() < 16);
    o1 = a1 && (q1.size() > 0);
    o2 = a2 && (q2.size() > 0);
    u1 = a1 && (q1.size() == 0);
    u2 = a2 && (q2.size() == 0);
    @(posedge clk); #1;
    idle();
    if (o1) hold1_m = q1.pop_front();
    if (o2) hold2_m = q2.pop_front();
    if (p1) q1.push_back(d);
    if (p2) q2.push_back(d);
    uf1_m = (uf1_m && !clr) || u1;
    uf2_m = (uf2_m && !clr) || u2;
  endtask

  task automatic drain();
    while (q1.size() > 0 || q2.size() > 0)
      tick(0, 0, '0, q1.size() > 0, q2.size() > 0, 0);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_clear();
    #3;
    total++; if (count1 !== 5'd0 || count2 !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d/%0d want 0/0", count1, count2); end
    total++; if (IN1 !== 12'h000 || IN2 !== 12'h000) begin bad++; $display("FAIL reset_in: got %h/%h want 000/000", IN1, IN2); end
    total++; if (wr_ready !== 1'b1 || underflow1 !== 1'b0 || underflow2 !== 1'b0) begin bad++; $display("FAIL reset_flags: rdy=%b uf=%b%b want 1 00", wr_ready, underflow1, underflow2); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_order();
    tick(1, 0, 12'h123, 0, 0, 0);
    tick(1, 0, 12'h456, 0, 0, 0);
    total++; if (IN1 !== 12'h123 || count1 !== 5'd2) begin bad++; $display("FAIL order_head: got %h cnt %0d want 123 cnt 2", IN1, count1); end
    tick(0, 0, '0, 1, 0, 0);
    total++; if (IN1 !== 12'h456 || count1 !== 5'd1) begin bad++; $display("FAIL order_pop: got %h cnt %0d want 456 cnt 1", IN1, count1); end
    drain();
  endtask

  task automatic test_independence();
    tick(1, 1, 12'hAAA, 0, 0, 0);
    tick(1, 0, 12'h555, 0, 0, 0);
    total++; if (IN2 !== 12'hAAA || IN1 !== 12'h555) begin bad++; $display("FAIL indep_heads: got %h/%h want 555/AAA", IN1, IN2); end
    tick(0, 0, '0, 0, 1, 0);
    total++; if (count2 !== 5'd0 || count1 !== 5'd1 || IN2 !== exp_in(2)) begin bad++; $display("FAIL indep_pop2: cnt %0d/%0d IN2 %h want 1/0 %h", count1, count2, IN2, exp_in(2)); end
    drain();
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 16; i++) tick(1, 0, 12'(i), 0, 0, 0);
    wr_sel = 0; #1;
    total++; if (wr_ready !== 1'b0 || count1 !== 5'd16) begin bad++; $display("FAIL full_state: rdy %b cnt %0d want 0 16", wr_ready, count1); end
    tick(1, 0, 12'h0AB, 0, 0, 0);
    total++; if (count1 !== 5'd16 || IN1 !== 12'h000) begin bad++; $display("FAIL full_drop: cnt %0d head %h want 16 000", count1, IN1); end
    for (int i = 0; i < 16; i++) begin
      total++; if (IN1 !== 12'(i)) begin bad++; $display("FAIL full_order[%0d]: got %h want %h", i, IN1, 12'(i)); end
      tick(0, 0, '0, 1, 0, 0);
    end
    tick(1, 0, 12'hFFF, 0, 0, 0);
    total++; if (IN1 !== 12'hFFF || count1 !== 5'd1) begin bad++; $display("FAIL wrap: got %h cnt %0d want FFF 1", IN1, count1); end
    drain();
  endtask

  task automatic test_underflow();
    tick(0, 0, '0, 0, 1, 0);
    total++; if (underflow2 !== 1'b1 || underflow1 !== 1'b0) begin bad++; $display("FAIL uf_set: got %b%b want uf2=1 uf1=0", underflow2, underflow1); end
    tick(0, 0, '0, 0, 0, 0);
    total++; if (underflow2 !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b want 1", underflow2); end
    tick(0, 0, '0, 0, 1, 1);
    total++; if (underflow2 !== 1'b1) begin bad++; $display("FAIL uf_set_wins: got %b want 1", underflow2); end
    tick(0, 0, '0, 0, 0, 1);
    total++; if (underflow2 !== 1'b0) begin bad++; $display("FAIL uf_clear: got %b want 0", underflow2); end
    // Push and pop on an empty channel together: push lands, pop is an underflow.
    tick(1, 0, 12'h3A5, 1, 0, 0);
    total++; if (count1 !== 5'd1 || underflow1 !== 1'b1 || IN1 !== 12'h3A5) begin bad++; $display("FAIL uf_empty_pushpop: cnt %0d uf %b head %h want 1 1 3A5", count1, underflow1, IN1); end
    tick(0, 0, '0, 0, 0, 1);
    drain();
  endtask

  task automatic test_back_to_back();
    tick(1, 0, 12'h111, 0, 0, 0);
    tick(1, 0, 12'h222, 0, 0, 0);
    tick(1, 0, 12'h333, 0, 0, 0);
    tick(1, 0, 12'h777, 1, 0, 0);
    total++; if (count1 !== 5'd3 || IN1 !== 12'h222) begin bad++; $display("FAIL b2b_count: cnt %0d head %h want 3 222", count1, IN1); end
    for (int i = 0; i < 2; i++) tick(0, 0, '0, 1, 0, 0);
    total++; if (IN1 !== 12'h777 || count1 !== 5'd1) begin bad++; $display("FAIL b2b_emerge: got %h cnt %0d want 777 1", IN1, count1); end
    tick(0, 0, '0, 1, 0, 0);
    total++; if (count1 !== 5'd0 || IN1 !== exp_in(1)) begin bad++; $display("FAIL b2b_empty: cnt %0d head %h want 0 %h", count1, IN1, exp_in(1)); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) tick(1, 0, 12'h100 + 12'(i), 0, 0, 0);
    total++; if (count1 !== 5'd5) begin bad++; $display("FAIL arst_pre: cnt %0d want 5", count1); end
    #2 rst_n = 0;
    #1;
    model_clear();
    total++; if (count1 !== 5'd0 || IN1 !== 12'h000 || wr_ready !== 1'b1) begin bad++; $display("FAIL arst_now: cnt %0d head %h rdy %b want 0 000 1", count1, IN1, wr_ready); end
    @(posedge clk); #1;
    rst_n = 1;
    tick(1, 0, 12'h3C3, 0, 0, 0);
    tick(0, 0, '0, 1, 0, 0);
    total++; if (count1 !== 5'd0 || IN1 !== exp_in(1)) begin bad++; $display("FAIL hold_after_pop: cnt %0d head %h want 0 %h", count1, IN1, exp_in(1)); end
  endtask

  task automatic test_random();
    logic wv, sel, a1, a2, clr;
    logic [11:0] d;
    for (int n = 0; n < 600; n++) begin
      // Alternate fill-biased and drain-biased phases so full and empty both occur.
      if ((n / 100) % 2 == 0) begin
        wv = ($urandom_range(0, 9) < 8); a1 = ($urandom_range(0, 9) < 2); a2 = ($urandom_range(0, 9) < 2);
      end else begin
        wv = ($urandom_range(0, 9) < 2); a1 = ($urandom_range(0, 9) < 7); a2 = ($urandom_range(0, 9) < 7);
      end
      sel = 1'($urandom); d = 12'($urandom); clr = ($urandom_range(0, 7) == 0);
      wr_sel = sel; #1;
      total++;
      if (IN1 !== exp_in(1) || IN2 !== exp_in(2) || count1 !== 5'(q1.size()) || count2 !== 5'(q2.size())
          || underflow1 !== uf1_m || underflow2 !== uf2_m
          || wr_ready !== ((sel ? q2.size() : q1.size()) < 16)) begin
        bad++;
        $display("FAIL random[%0d]: IN %h/%h cnt %0d/%0d uf %b%b rdy %b want IN %h/%h cnt %0d/%0d uf %b%b rdy %b",
                 n, IN1, IN2, count1, count2, underflow1, underflow2, wr_ready,
                 exp_in(1), exp_in(2), q1.size(), q2.size(), uf1_m, uf2_m,
                 (sel ? q2.size() : q1.size()) < 16);
      end
      tick(wv, sel, d, a1, a2, clr);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_independence();
    test_full_wrap();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
